// File: rtl/processing_element_cfg.sv
// processing_element_cfg
//   Parametrised systolic-array processing element. Activations flow left to
//   right, partial sums / operands flow top to bottom, and weights shift top
//   to bottom through a dedicated chain. Two dataflows are supported:
//     weight-stationary (mode=0): out_b = in_b + in_a * w_reg
//     output-stationary (mode=1): acc  += in_a * in_b[DWIDTH-1:0], drained on out_c
//   Overflow either clamps (SAT=1) or wraps (SAT=0) and always sets sat_flag.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   mode                   dataflow select, latched when a run starts
//   w_load, w_in, w_out    weight shift chain
//   in_a, in_a_valid       activation from the left
//   in_b, in_b_valid       psum (WS) or operand (OS) from above
//   drain                  OS: emit accumulator on out_c
//   out_a, out_a_valid     activation to the right, 1-cycle delay
//   out_b, out_b_valid     psum (WS) or operand (OS) to below
//   out_c, out_c_valid     drained OS result, valid pulses for one cycle
//   sat_flag               sticky overflow indicator

module processing_element_cfg #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 19,
    parameter bit SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              w_load,
    input  logic [DWIDTH-1:0] w_in,
    output logic [DWIDTH-1:0] w_out,
    input  logic [DWIDTH-1:0] in_a,
    input  logic              in_a_valid,
    input  logic [AWIDTH-1:0] in_b,
    input  logic              in_b_valid,
    input  logic              drain,
    output logic [DWIDTH-1:0] out_a,
    output logic              out_a_valid,
    output logic [AWIDTH-1:0] out_b,
    output logic              out_b_valid,
    output logic [AWIDTH-1:0] out_c,
    output logic              out_c_valid,
    output logic              sat_flag
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [AWIDTH-1:0] ACC_MAX = {1'b0, {(AWIDTH-1){1'b1}}};
    localparam logic [AWIDTH-1:0] ACC_MIN = {1'b1, {(AWIDTH-1){1'b0}}};

    state_t              state, state_next;
    logic [DWIDTH-1:0]   w_reg;
    logic [AWIDTH-1:0]   acc;
    logic                mode_reg;

    logic                any_valid, both_valid;
    logic                idle_start, process, eff_os, shift;
    logic                mac_fire, idle_drain, do_drain;
    logic [DWIDTH-1:0]   op;
    logic [2*DWIDTH-1:0] a_ext, op_ext, prod;
    logic [AWIDTH-1:0]   addend;
    logic [AWIDTH:0]     sum;
    logic                ovf;
    logic [AWIDTH-1:0]   result;

    // Control decode. A run starts in the same cycle the first valid arrives
    // while idle, so that cycle is processed with the live mode input rather
    // than the (not yet updated) latched mode.
    always_comb begin
        any_valid  = in_a_valid | in_b_valid;
        both_valid = in_a_valid & in_b_valid;
        idle_start = (state == IDLE) && !w_load && any_valid;
        process    = (state == RUN) || idle_start;
        eff_os     = (state == IDLE) ? mode : mode_reg;
        shift      = w_load && ((state == IDLE) || (state == LOAD));
        mac_fire   = process && both_valid;
        idle_drain = (state == IDLE) && !w_load && !any_valid && drain;
        do_drain   = idle_drain || (process && eff_os && drain);
    end

    // Shared multiply-add. The sum is one bit wider than the accumulator so a
    // disagreement between its top two bits signals signed overflow.
    always_comb begin
        op     = eff_os ? in_b[DWIDTH-1:0] : w_reg;
        a_ext  = {{DWIDTH{in_a[DWIDTH-1]}}, in_a};
        op_ext = {{DWIDTH{op[DWIDTH-1]}}, op};
        prod   = a_ext * op_ext;
        addend = eff_os ? acc : in_b;
        sum    = {addend[AWIDTH-1], addend}
               + {{(AWIDTH+1-2*DWIDTH){prod[2*DWIDTH-1]}}, prod};
        ovf    = sum[AWIDTH] ^ sum[AWIDTH-1];
        if (ovf && SAT) begin
            result = sum[AWIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            result = sum[AWIDTH-1:0];
        end
    end

    // Next-state logic; in RUN a drain request (OS only) wins over the
    // no-valid exit so a drain can be issued on an otherwise empty cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (w_load) begin
                    state_next = LOAD;
                end else if (any_valid) begin
                    state_next = (mode && drain) ? DRAIN : RUN;
                end else if (drain) begin
                    state_next = DRAIN;
                end
            end
            LOAD:    state_next = w_load ? LOAD : IDLE;
            RUN: begin
                if (mode_reg && drain) begin
                    state_next = DRAIN;
                end else if (!any_valid) begin
                    state_next = IDLE;
                end
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. Data registers only move on a valid qualifier so an
    // X on invalid data never reaches an output. The drain assignment to acc
    // comes last so it overrides a same-cycle accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_reg    <= 1'b0;
            w_reg       <= '0;
            w_out       <= '0;
            acc         <= '0;
            out_a       <= '0;
            out_a_valid <= 1'b0;
            out_b       <= '0;
            out_b_valid <= 1'b0;
            out_c       <= '0;
            sat_flag    <= 1'b0;
        end else begin
            state <= state_next;
            if (idle_start) begin
                mode_reg <= mode;
            end
            if (shift) begin
                w_out <= w_reg;
                w_reg <= w_in;
            end
            if (process) begin
                out_a_valid <= in_a_valid;
                if (in_a_valid) begin
                    out_a <= in_a;
                end
                if (eff_os) begin
                    out_b_valid <= in_b_valid;
                    if (in_b_valid) begin
                        out_b <= in_b;
                    end
                    if (mac_fire) begin
                        acc <= result;
                    end
                end else begin
                    out_b_valid <= mac_fire;
                    if (mac_fire) begin
                        out_b <= result;
                    end
                end
            end else begin
                out_a_valid <= 1'b0;
                out_b_valid <= 1'b0;
            end
            if (do_drain) begin
                out_c <= mac_fire ? result : acc;
                acc   <= '0;
            end
            sat_flag <= (do_drain ? 1'b0 : sat_flag) | (mac_fire & ovf);
        end
    end

    assign out_c_valid = (state == DRAIN);

endmodule
